// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one 32-bit read at a time to the bus
// bridge, buffers the returned instruction for decode, and follows PC
// redirects from execute. A request that is already in flight when a
// redirect arrives is completed on the bus and its data is discarded.
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_addr,
  output logic [1:0]  if_size,
  input  logic [63:0] if_data_read,
  input  logic [1:0]  if_resp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] inst_pc,
  output logic [31:0] inst,
  output logic        inst_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [63:0] pc, pc_d;
  logic [63:0] req_addr, req_addr_d;
  logic        capture;

  // Bus request is presented while issuing or draining a discarded fetch.
  assign if_valid   = (state == REQ) || (state == DROP);
  assign inst_valid = (state == HOLD);
  assign if_addr    = req_addr;
  assign if_size    = 2'b10;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic plus next values for the fetch PC and request address.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    req_addr_d = req_addr;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
        end else begin
          req_addr_d = pc;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = if_ready ? IDLE : DROP;
        end else if (if_ready) begin
          capture = 1'b1;
          pc_d    = req_addr + 64'd4;
          state_d = HOLD;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (if_ready)       state_d = IDLE;
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = REQ;
        end else if (inst_ready) begin
          req_addr_d = pc;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch PC and request address registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      pc       <= pc_d;
      req_addr <= req_addr_d;
    end
  end

  // Instruction buffer: loaded only when a non-discarded response arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else if (capture) begin
      inst       <= req_addr[2] ? if_data_read[63:32] : if_data_read[31:0];
      inst_pc    <= req_addr;
      inst_fault <= (if_resp != 2'b00);
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a bus-bridge responder with random latency,
// random redirects and decode back-pressure, checked against a
// transaction-level model of the expected instruction stream.
module tb_if_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic [63:0] if_data_read = '0;
  logic [1:0]  if_resp = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] inst_pc;
  logic [31:0] inst;
  logic        inst_fault;

  always #5 clock = ~clock;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_addr        (if_addr),
    .if_size        (if_size),
    .if_data_read   (if_data_read),
    .if_resp        (if_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst           (inst),
    .inst_fault     (inst_fault)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Memory image: two fixed words at the reset vector, hashed contents elsewhere.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 32'h0000_0413;
    if (a == 64'h0000_0000_8000_0004) return 32'h00A0_0513;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  // Bus response per address; a few addresses return SLVERR/DECERR/EXOKAY.
  function automatic logic [1:0] resp_at(input logic [63:0] a);
    logic [31:0] h;
    if (a[63:3] == 61'h1000_0000) return 2'b00;
    h = (a[31:0] * 32'h85EB_CA6B) >> 29;
    case (h)
      32'd3:   return 2'b10;
      32'd5:   return 2'b11;
      32'd6:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [63:0] pick_target();
    logic [63:0] r;
    case ($urandom_range(0, 3))
      0: r = 64'h0000_0000_8000_1000;
      1: r = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 1) * 4);
      2: r = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 255) * 4);
      default: begin
        r = {$urandom, $urandom};
        r[1:0] = 2'b00;
      end
    endcase
    return r;
  endfunction

  // Reference model state: next PC decode should see, plus previous-cycle snapshot.
  logic [63:0] exp_pc;
  logic        dropped, kill;
  logic        prev_fire, prev_kill, prev_if_valid, prev_if_ready;
  logic        prev_inst_valid, prev_inst_ready, prev_redirect;
  logic [63:0] prev_if_addr, prev_inst_pc;
  logic [31:0] prev_inst;
  logic        prev_inst_fault;
  int unsigned transfers = 0;
  int unsigned bcnt;
  int unsigned hold_cnt;
  logic        no_redir;

  task automatic init_model();
    exp_pc          = RST_PC;
    dropped         = 1'b0;
    prev_fire       = 1'b0;
    prev_kill       = 1'b0;
    prev_if_valid   = 1'b0;
    prev_if_ready   = 1'b0;
    prev_inst_valid = 1'b0;
    prev_inst_ready = 1'b0;
    prev_redirect   = 1'b0;
    prev_if_addr    = '0;
    prev_inst_pc    = '0;
    prev_inst       = '0;
    prev_inst_fault = 1'b0;
    bcnt            = 1;
    hold_cnt        = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_if_valid"},   if_valid,   0);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_inst"},       inst,       0);
    chk({tag, "_inst_pc"},    inst_pc,    0);
    chk({tag, "_inst_fault"}, inst_fault, 0);
    chk({tag, "_if_addr"},    if_addr,    RST_PC);
  endtask

  // One clock: drive stimulus after the rising edge, check on the falling edge.
  task automatic step();
    logic [63:0] aligned;
    @(posedge clock);
    #1;
    if (if_valid) begin
      if (bcnt == 0) begin
        if_ready     = 1'b1;
        aligned      = {if_addr[63:3], 3'b000};
        if_data_read = {word_at(aligned + 64'd4), word_at(aligned)};
        if_resp      = resp_at(if_addr);
        bcnt         = $urandom_range(0, 3);
      end else begin
        if_ready     = 1'b0;
        if_data_read = {$urandom, $urandom};
        if_resp      = 2'($urandom);
        bcnt--;
      end
    end else begin
      if_ready     = ($urandom_range(0, 15) == 0);
      if_data_read = {$urandom, $urandom};
      if_resp      = 2'($urandom);
    end
    if (!no_redir && $urandom_range(0, 7) == 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = pick_target();
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = {$urandom, $urandom};
    end
    if (hold_cnt > 0) begin
      inst_ready = 1'b0;
      hold_cnt--;
    end else if ($urandom_range(0, 19) == 0) begin
      inst_ready = 1'b0;
      hold_cnt   = 5;
    end else begin
      inst_ready = ($urandom_range(0, 3) != 0);
    end

    @(negedge clock);
    if (prev_fire) begin
      chk("if_valid_low_after_ready", if_valid, 0);
      chk("inst_valid_after_ready", inst_valid, !prev_kill);
    end else if (prev_if_valid) begin
      chk("if_valid_held", if_valid, 1);
      chk("if_addr_stable", if_addr, prev_if_addr);
    end
    if (prev_inst_valid) begin
      if (!prev_inst_ready && !prev_redirect) begin
        chk("hold_inst_valid", inst_valid, 1);
        chk("hold_inst", inst, prev_inst);
        chk("hold_inst_pc", inst_pc, prev_inst_pc);
        chk("hold_inst_fault", inst_fault, prev_inst_fault);
      end else begin
        chk("hold_exit_inst_valid", inst_valid, 0);
        chk("hold_exit_if_valid", if_valid, 1);
      end
    end
    if (!prev_if_valid && !prev_inst_valid)
      chk("idle_one_cycle", if_valid, 1);
    if (if_valid && !prev_if_valid)
      chk("req_addr", if_addr, exp_pc);
    if (if_valid)
      chk("if_size", if_size, 2'b10);
    chk("valid_exclusive", if_valid & inst_valid, 0);
    if (inst_valid && inst_ready) begin
      chk("xfer_inst_pc", inst_pc, exp_pc);
      chk("xfer_inst", inst, word_at(exp_pc));
      chk("xfer_inst_fault", inst_fault, resp_at(exp_pc) != 2'b00);
      transfers++;
      exp_pc = exp_pc + 64'd4;
    end

    kill      = dropped || redirect_valid;
    prev_fire = if_valid && if_ready;
    prev_kill = kill;
    dropped   = (if_valid && !if_ready) ? kill : 1'b0;
    if (redirect_valid) exp_pc = redirect_pc;

    prev_if_valid   = if_valid;
    prev_if_ready   = if_ready;
    prev_if_addr    = if_addr;
    prev_inst_valid = inst_valid;
    prev_inst_ready = inst_ready;
    prev_redirect   = redirect_valid;
    prev_inst       = inst;
    prev_inst_pc    = inst_pc;
    prev_inst_fault = inst_fault;
  endtask

  // Assert reset while a request is outstanding, then resume from RESET_PC.
  task automatic reset_mid_request();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_req_active", seen, 1);
    #2 reset = 1'b0;
    #1 check_reset_values("rst_async");
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_values("rst_held");
    reset = 1'b1;
    init_model();
  endtask

  initial begin
    no_redir = 1'b1;
    init_model();
    repeat (3) @(negedge clock);
    check_reset_values("rst_init");
    reset = 1'b1;

    repeat (20) step();
    no_redir = 1'b0;
    repeat (1500) step();

    reset_mid_request();
    repeat (1500) step();

    chk("liveness", transfers >= 100, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000; first fetch address after reset.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clock.
REQ-004 SHALL have port if_valid  out  1  fetch request to the AXI read/write bridge.
REQ-005 SHALL have port if_ready  in  1  one-cycle completion pulse from the bridge.
REQ-006 SHALL have port if_addr  out  64  request address.
REQ-007 SHALL have port if_size  out  2  request size, constant 2'b10 (32-bit).
REQ-008 SHALL have port if_data_read  in  64  doubleword-aligned read data, valid with if_ready.
REQ-009 SHALL have port if_resp  in  2  AXI response, valid with if_ready; nonzero = error.
REQ-010 SHALL have port redirect_valid  in  1  one-cycle PC redirect from execute.
REQ-011 SHALL have port redirect_pc  in  64  redirect target, valid with redirect_valid.
REQ-012 SHALL have port inst_valid  out  1  instruction available to decode.
REQ-013 SHALL have port inst_ready  in  1  decode accepts instruction.
REQ-014 SHALL have port inst_pc  out  64  PC of presented instruction.
REQ-015 SHALL have port inst  out  32  presented instruction.
REQ-016 SHALL have port inst_fault  out  1  presented instruction's fetch returned nonzero if_resp.

Function
REQ-017 SHALL implement states IDLE, REQ, DROP, HOLD; if_valid = 1 exactly in REQ and DROP; inst_valid = 1 exactly in HOLD.
REQ-018 SHALL hold pc register (next fetch PC) and req_addr register; if_addr = req_addr; req_addr constant while if_valid = 1.
REQ-019 IDLE: next cycle -> REQ, req_addr <= pc; no other action unless redirect (pc <= redirect_pc first).
REQ-020 REQ, if_ready=1, redirect_valid=0: inst <= if_data_read[63:32] if req_addr[2]=1 else [31:0]; inst_pc <= req_addr; inst_fault <= (if_resp != 0); pc <= req_addr + 4 (64-bit wrap); -> HOLD.
REQ-021 REQ, redirect_valid=1, if_ready=0: pc <= redirect_pc; -> DROP; if_valid and if_addr unchanged.
REQ-022 REQ, redirect_valid=1, if_ready=1: response discarded; pc <= redirect_pc; -> IDLE.
REQ-023 DROP, if_ready=1: response discarded; -> IDLE. DROP, redirect_valid=1: pc <= redirect_pc (latest wins), regardless of if_ready.
REQ-024 HOLD, inst_ready=1, redirect_valid=0: transfer completes; req_addr <= pc; -> REQ.
REQ-025 HOLD, redirect_valid=1: pc <= redirect_pc; req_addr <= redirect_pc; -> REQ; buffered instruction dropped unless inst_ready=1 same cycle (then counted as transferred).
REQ-026 HOLD, inst_ready=0: inst, inst_pc, inst_fault stable.
REQ-027 if_valid SHALL be low for at least one cycle after every if_ready pulse.
REQ-028 if_ready outside REQ/DROP SHALL be ignored.
REQ-029 inst_fault does not stop fetching; next fetch proceeds at pc+4.
REQ-030 Minimum issue-to-decode latency: inst_valid rises cycle after if_ready.

Reset
REQ-031 While reset=0: state IDLE, pc = RESET_PC, req_addr = RESET_PC, inst = 0, inst_pc = 0, inst_fault = 0, if_valid = 0, inst_valid = 0.
REQ-032 Reset mid-request SHALL abandon the transaction; after release, first request is at RESET_PC within 2 cycles.

Verification
REQ-033 Release reset -> if_valid=1 with if_addr=0x80000000, if_size=2'b10 on 2nd cycle.
REQ-034 if_ready with if_data_read=64'h00A00513_00000413 for 0x80000000 then 0x80000004 -> inst 0x00000413 then 0x00A00513, inst_pc 0x80000000 then 0x80000004.
REQ-035 inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, if_valid=0 throughout; next request only after inst_ready.
REQ-036 redirect_valid to 0x80001000 while REQ without if_ready -> DROP, if_addr unchanged until if_ready; that data never reaches decode; next if_addr=0x80001000.
REQ-037 redirect and if_ready same cycle -> no inst_valid; IDLE one cycle; next if_addr=redirect_pc.
REQ-038 if_resp=2'b10 -> inst_fault=1 with that inst_pc; next fetch at inst_pc+4 with inst_fault=0 on OKAY.
